// File: rtl/const_mult_pkg.sv
// Shared widths, operand/result types and elaboration-time CSD recoding for the
// 2-bit signed constant multiplier.
package const_mult_pkg;

  localparam int BIT_WIDTH   = 2;
  localparam int COEFF_WIDTH = 8;
  localparam int OUT_WIDTH   = BIT_WIDTH + COEFF_WIDTH;

  typedef logic signed [BIT_WIDTH-1:0] operand_t;
  typedef logic signed [OUT_WIDTH-1:0] result_t;

  // Non-adjacent-form digit k of coeff: -1, 0 or +1. Peels digits from the LSB,
  // picking +/-1 on odd values so the remainder is divisible by 4.
  function automatic int csd_digit(input int coeff, input int k);
    int c;
    int d;
    c = coeff;
    d = 0;
    for (int i = 0; i <= k; i++) begin
      if ((c & 1) == 0) begin
        d = 0;
      end else if ((c & 3) == 1) begin
        d = 1;
      end else begin
        d = -1;
      end
      c = (c - d) >>> 1;
    end
    return d;
  endfunction

endpackage

// File: rtl/csd_shift_add.sv
// Combinational shift-and-add network computing inp * COEFF from its CSD digits;
// zero latency, no flow control. Zero digits collapse to plain wires.
module csd_shift_add #(
  parameter int COEFF     = -73,
  parameter int OUT_WIDTH = const_mult_pkg::OUT_WIDTH
) (
  input  const_mult_pkg::operand_t     inp,
  output logic signed [OUT_WIDTH-1:0]  prod
);

  localparam int IN_W = $bits(const_mult_pkg::operand_t);

  logic signed [OUT_WIDTH-1:0] w_ext;
  logic signed [OUT_WIDTH-1:0] w_acc [0:OUT_WIDTH];

  assign w_ext    = {{(OUT_WIDTH-IN_W){inp[IN_W-1]}}, inp};
  assign w_acc[0] = '0;

  // Partial sums wrap modulo 2^OUT_WIDTH; the final sum always fits, so it is exact.
  for (genvar k = 0; k < OUT_WIDTH; k++) begin : g_digit
    localparam int D = const_mult_pkg::csd_digit(COEFF, k);
    if (D > 0) begin : g_pos
      assign w_acc[k+1] = w_acc[k] + (w_ext <<< k);
    end else if (D < 0) begin : g_neg
      assign w_acc[k+1] = w_acc[k] - (w_ext <<< k);
    end else begin : g_zero
      assign w_acc[k+1] = w_acc[k];
    end
  end

  assign prod = w_acc[OUT_WIDTH];

endmodule

// File: rtl/const_mult_int2b.sv
// Registered signed constant multiplier, out = trunc(inp * COEFF); 1-cycle latency,
// throughput 1/cycle, no backpressure (in_valid only qualifies out_valid).
module const_mult_int2b
  import const_mult_pkg::*;
#(
  parameter int COEFF       = -73,
  parameter int APPROX_LSBS = 0
) (
  input  logic     clk,
  input  logic     rst,
  input  operand_t inp,
  input  logic     in_valid,
  output result_t  out,
  output logic     out_valid
);

  // Clears the approximated LSBs while keeping the sign bit intact.
  localparam result_t LSB_MASK = {OUT_WIDTH{1'b1}} << APPROX_LSBS;

  result_t w_prod;
  result_t w_trunc;
  result_t r_out;
  logic    r_out_valid;

  csd_shift_add #(
    .COEFF     (COEFF),
    .OUT_WIDTH (OUT_WIDTH)
  ) u_csd (
    .inp  (inp),
    .prod (w_prod)
  );

  assign w_trunc = w_prod & LSB_MASK;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_out       <= w_trunc;
      r_out_valid <= in_valid;
    end
  end

  assign out       = r_out;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_const_mult_int2b.sv
// Bench for const_mult_int2b: default, APPROX_LSBS=3 and COEFF=-128 instances
// share one stimulus stream and are checked against an integer reference model.
module tb_const_mult_int2b;

  typedef struct {
    logic signed [9:0] e_exact;
    logic signed [9:0] e_apx;
    logic signed [9:0] e_ext;
    logic              e_vld;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic signed [1:0] inp = 2'sd0;
  logic              in_valid = 1'b0;

  logic signed [9:0] out_exact, out_apx, out_ext;
  logic              vld_exact, vld_apx, vld_ext;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  const_mult_int2b u_exact (
    .clk(clk), .rst(rst), .inp(inp), .in_valid(in_valid),
    .out(out_exact), .out_valid(vld_exact)
  );

  const_mult_int2b #(.APPROX_LSBS(3)) u_apx (
    .clk(clk), .rst(rst), .inp(inp), .in_valid(in_valid),
    .out(out_apx), .out_valid(vld_apx)
  );

  const_mult_int2b #(.COEFF(-128)) u_ext (
    .clk(clk), .rst(rst), .inp(inp), .in_valid(in_valid),
    .out(out_ext), .out_valid(vld_ext)
  );

  function automatic exp_t model(input logic r, input int a, input logic v);
    exp_t e;
    int   p;
    p         = a * -73;
    e.e_exact = r ? 10'sd0 : 10'(p);
    e.e_apx   = r ? 10'sd0 : 10'(p & ~7);
    e.e_ext   = r ? 10'sd0 : 10'(a * -128);
    e.e_vld   = r ? 1'b0 : v;
    return e;
  endfunction

  task automatic check_outputs();
    exp_t e;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty: got 0 entries, required 1");
      return;
    end
    e = sb.pop_front();
    checks++;
    assert (out_exact === e.e_exact) else begin
      errors++;
      $error("FAIL out_exact: got %0d, required %0d", out_exact, e.e_exact);
    end
    checks++;
    assert (out_apx === e.e_apx) else begin
      errors++;
      $error("FAIL out_apx3: got %0d, required %0d", out_apx, e.e_apx);
    end
    checks++;
    assert (out_ext === e.e_ext) else begin
      errors++;
      $error("FAIL out_coeff_m128: got %0d, required %0d", out_ext, e.e_ext);
    end
    checks++;
    assert (vld_exact === e.e_vld) else begin
      errors++;
      $error("FAIL vld_exact: got %b, required %b", vld_exact, e.e_vld);
    end
    checks++;
    assert (vld_apx === e.e_vld) else begin
      errors++;
      $error("FAIL vld_apx3: got %b, required %b", vld_apx, e.e_vld);
    end
    checks++;
    assert (vld_ext === e.e_vld) else begin
      errors++;
      $error("FAIL vld_coeff_m128: got %b, required %b", vld_ext, e.e_vld);
    end
  endtask

  // Apply one cycle of stimulus, record its expected result, then check it.
  task automatic drive(input logic r, input int a, input logic v);
    rst      = r;
    inp      = 2'(a);
    in_valid = v;
    sb.push_back(model(r, a, v));
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    @(negedge clk);
    // Reset held for three cycles with a valid operand present.
    for (int i = 0; i < 3; i++) drive(1'b1, 1, 1'b1);
    // First cycle after release.
    drive(1'b0, 1, 1'b1);
    // All four operand codes back to back.
    drive(1'b0, -2, 1'b1);
    drive(1'b0, -1, 1'b1);
    drive(1'b0, 0, 1'b1);
    drive(1'b0, 1, 1'b1);
    // out follows inp even when in_valid is low.
    drive(1'b0, 1, 1'b0);
    drive(1'b0, 1, 1'b1);
    drive(1'b0, -2, 1'b0);
    // Mid-stream reset pulse, then the stream resumes.
    drive(1'b0, -1, 1'b1);
    drive(1'b0, -1, 1'b1);
    drive(1'b1, -1, 1'b1);
    drive(1'b0, -1, 1'b1);
    drive(1'b0, -2, 1'b1);
    // Randomised tail with occasional resets.
    for (int i = 0; i < 40; i++) begin
      drive(($urandom_range(0, 9) == 0), int'($urandom_range(0, 3)) - 2,
            1'($urandom_range(0, 1)));
    end
    rst = 1'b0;
    in_valid = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
